// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: round-robin share of the ULPI SIE register port between two requesters
// Ports:
//   i_clk, i_rst_n                     60 MHz ULPI clock, async active-low reset
//   i_reqN_valid/cmd/wd                request from port N (held until o_reqN_ack)
//   o_reqN_ack/rd/err                  one-cycle completion pulse with read data and error flag
//   o_sie_en/cmd/regwd                 start strobe and operands towards the SIE
//   i_sie_regrd/busy                   read data and busy from the SIE
// Params: TIMEOUT cycles allowed in each SIE wait state before the transaction is aborted
module ulpi_reg_arbiter #(
  parameter int TIMEOUT = 200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_cmd,
  input  logic [7:0] i_req0_wd,
  output logic       o_req0_ack,
  output logic [7:0] o_req0_rd,
  output logic       o_req0_err,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_cmd,
  input  logic [7:0] i_req1_wd,
  output logic       o_req1_ack,
  output logic [7:0] o_req1_rd,
  output logic       o_req1_err,
  output logic       o_sie_en,
  output logic [7:0] o_sie_cmd,
  output logic [7:0] o_sie_regwd,
  input  logic [7:0] i_sie_regrd,
  input  logic       i_sie_busy
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;
  state_t     r_state;
  logic       r_last, r_port, r_sie_en;
  logic [7:0] r_cmd, r_wd, r_cnt;
  logic       r_ack0, r_ack1, r_err0, r_err1;
  logic [7:0] r_rd0, r_rd1;
  logic       w_req, w_gnt, w_tmo, w_done_ok, w_to_resp, w_port, w_err;
  logic [7:0] w_sel_cmd, w_sel_wd, w_rd;
  assign w_req     = i_req0_valid | i_req1_valid;
  // on contention the port that did not win last time is granted
  assign w_gnt     = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
  assign w_sel_cmd = w_gnt ? i_req1_cmd : i_req0_cmd;
  assign w_sel_wd  = w_gnt ? i_req1_wd : i_req0_wd;
  // counter starts at 0 on state entry, so TIMEOUT-1 marks the last allowed wait cycle
  assign w_tmo     = r_cnt >= 8'(TIMEOUT - 1);
  assign w_done_ok = (r_state == S_WAIT_DONE) & ~i_sie_busy;
  // cmd[7]=1 covers both legal encodings 10 (write) and 11 (read)
  assign w_to_resp = ((r_state == S_IDLE) & w_req & ~w_sel_cmd[7]) |
                     ((r_state == S_WAIT_BUSY) & ~i_sie_busy & w_tmo) |
                     ((r_state == S_WAIT_DONE) & (~i_sie_busy | w_tmo));
  assign w_port    = (r_state == S_IDLE) ? w_gnt : r_port;
  assign w_err     = ~w_done_ok;
  assign w_rd      = (w_done_ok & r_cmd[6]) ? i_sie_regrd : 8'h00;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_sie_en <= 1'b0;
      r_cmd    <= 8'h00;
      r_wd     <= 8'h00;
      r_cnt    <= 8'h00;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rd0    <= 8'h00;
      r_rd1    <= 8'h00;
    end else begin
      r_ack0   <= w_to_resp & ~w_port;
      r_ack1   <= w_to_resp & w_port;
      r_err0   <= w_to_resp & ~w_port & w_err;
      r_err1   <= w_to_resp & w_port & w_err;
      r_rd0    <= (w_to_resp & ~w_port) ? w_rd : 8'h00;
      r_rd1    <= (w_to_resp & w_port) ? w_rd : 8'h00;
      r_sie_en <= 1'b0;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_port   <= w_gnt;
          r_last   <= w_gnt;
          r_cmd    <= w_sel_cmd;
          r_wd     <= w_sel_wd;
          r_sie_en <= w_sel_cmd[7];
          r_state  <= w_sel_cmd[7] ? S_ISSUE : S_RESP;
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
          r_cnt   <= 8'h00;
        end
        S_WAIT_BUSY: if (i_sie_busy) begin
          r_state <= S_WAIT_DONE;
          r_cnt   <= 8'h00;
        end else if (w_tmo) r_state <= S_RESP;
        else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        S_WAIT_DONE: if (!i_sie_busy || w_tmo) r_state <= S_RESP;
        else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_sie_en    = r_sie_en;
  assign o_sie_cmd   = r_cmd;
  assign o_sie_regwd = r_wd;
  assign o_req0_ack  = r_ack0;
  assign o_req0_rd   = r_rd0;
  assign o_req0_err  = r_err0;
  assign o_req1_ack  = r_ack1;
  assign o_req1_rd   = r_rd1;
  assign o_req1_err  = r_err1;
endmodule
